// File: rtl/aud_ctrl_pkg.sv
// Shared types for the audio playback sequencer: FSM state encoding (also
// exported on o_state), speed mode, and the pending-read target tag.
package aud_ctrl_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_CUR = 3'd1,
        ST_FETCH_NXT = 3'd2,
        ST_WAIT_TICK = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_FAST   = 2'd1,
        MODE_SLOW   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_CUR  = 2'd1,
        PEND_NXT  = 2'd2
    } pend_e;

    // Fast wins over slow when both are requested.
    function automatic mode_e sel_mode(input logic fast, input logic slow);
        if (fast) return MODE_FAST;
        if (slow) return MODE_SLOW;
        return MODE_NORMAL;
    endfunction

endpackage

// File: rtl/aud_interp.sv
// Output sample selection: zero-order hold of cur, or linear step between
// cur and nxt at phase k/N with an arithmetic-shift divide.
module aud_interp
    import aud_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] cur,
    input  logic signed [DATA_W-1:0] nxt,
    input  logic        [2:0]        k,
    input  logic        [1:0]        rate_log2,
    input  logic                     interp,
    output logic signed [DATA_W-1:0] sample
);

    localparam int PROD_W = DATA_W + 4;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] k_ext;
    logic signed [PROD_W-1:0] cur_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] step;

    // k < N keeps the result between cur and nxt, so truncation cannot overflow.
    always_comb begin
        diff     = {nxt[DATA_W-1], nxt} - {cur[DATA_W-1], cur};
        diff_ext = {{3{diff[DATA_W]}}, diff};
        k_ext    = {{(PROD_W-3){1'b0}}, k};
        cur_ext  = {{4{cur[DATA_W-1]}}, cur};
        prod     = diff_ext * k_ext;
        step     = prod >>> rate_log2;
        sample   = interp ? DATA_W'(cur_ext + step) : cur;
    end

endmodule

// File: rtl/aud_play_ctrl.sv
// Playback sequencer: fetches samples from SRAM, applies fast/slow/normal
// speed, and presents one sample per DACLRCK frame to the I2S serializer.
//
// state     | meaning
// IDLE      | stopped, pointer at 0
// FETCH_CUR | reading sample at ptr into cur
// FETCH_NXT | reading sample at min(ptr+1,end) into nxt (slow interp)
// WAIT_TICK | cur/nxt ready, waiting for frame tick to emit
// PAUSE     | halted, ptr/k held, in-flight read still lands
// DONE      | one-cycle end-of-record pulse, then IDLE
module aud_play_ctrl
    import aud_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow,
    input  logic [1:0]        i_rate_log2,
    input  logic              i_interp,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_daclrck,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_rd,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic [2:0]        o_state,
    output logic              o_done,
    output logic              o_underrun
);

    localparam int LAT_W = $clog2(RD_LAT + 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    pend_e               pend_q, pend_d;
    logic [1:0]          rate_q, rate_d;
    logic                interp_q, interp_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [2:0]          k_q, k_d;
    logic [DATA_W-1:0]   cur_q, cur_d;
    logic [DATA_W-1:0]   nxt_q, nxt_d;
    logic [LAT_W-1:0]    wait_q, wait_d;
    logic                lrck_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   dac_q, dac_d;
    logic                en_q, en_d;
    logic                done_q, done_d;
    logic                under_q, under_d;

    logic                tick;
    logic                fetch_done;
    logic                adv;
    logic                k_last;
    logic [3:0]          n_val;
    logic [ADDR_W:0]     end_ext;
    logic [ADDR_W:0]     ptr_inc1;
    logic [ADDR_W:0]     new_ptr;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [DATA_W-1:0]   sample;

    aud_interp #(.DATA_W(DATA_W)) u_interp (
        .cur       (cur_q),
        .nxt       (nxt_q),
        .k         (k_q),
        .rate_log2 (rate_q),
        .interp    (interp_q && (mode_q == MODE_SLOW)),
        .sample    (sample)
    );

    always_comb begin
        tick       = i_daclrck & ~lrck_q;
        fetch_done = (pend_q != PEND_NONE) && (wait_q == '0);
        n_val      = 4'd1 << rate_q;
        k_last     = (k_q == (n_val[2:0] - 3'd1));
        end_ext    = {1'b0, i_end_addr};
        ptr_inc1   = {1'b0, ptr_q} + (ADDR_W+1)'(1);
        nxt_addr   = (ptr_inc1 > end_ext) ? i_end_addr : ptr_inc1[ADDR_W-1:0];
        adv        = 1'b0;
        new_ptr    = ptr_inc1;

        state_d  = state_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        rate_d   = rate_q;
        interp_d = interp_q;
        ptr_d    = ptr_q;
        k_d      = k_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        dac_d    = dac_q;
        rd_d     = 1'b0;
        under_d  = 1'b0;

        // An issued read always lands, whatever the FSM does meanwhile.
        if (pend_q != PEND_NONE) begin
            if (wait_q == '0) begin
                if (pend_q == PEND_CUR) cur_d = i_sram_data;
                else                    nxt_d = i_sram_data;
                pend_d = PEND_NONE;
            end else begin
                wait_d = wait_q - LAT_W'(1);
            end
        end

        if (i_stop) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            k_d     = '0;
            dac_d   = '0;
            pend_d  = PEND_NONE;
        end else if (i_pause && (state_q inside {ST_FETCH_CUR, ST_FETCH_NXT, ST_WAIT_TICK})) begin
            state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (i_start) begin
                        if (state_q == ST_IDLE) begin
                            ptr_d = '0;
                            k_d   = '0;
                        end
                        mode_d   = sel_mode(i_fast, i_slow);
                        rate_d   = i_rate_log2;
                        interp_d = i_interp;
                        addr_d   = (state_q == ST_IDLE) ? '0 : ptr_q;
                        rd_d     = 1'b1;
                        pend_d   = PEND_CUR;
                        wait_d   = LAT_W'(RD_LAT);
                        state_d  = ST_FETCH_CUR;
                    end
                end
                ST_FETCH_CUR: begin
                    under_d = tick;
                    if (fetch_done) begin
                        if (mode_q == MODE_SLOW && interp_q) begin
                            addr_d  = nxt_addr;
                            rd_d    = 1'b1;
                            pend_d  = PEND_NXT;
                            wait_d  = LAT_W'(RD_LAT);
                            state_d = ST_FETCH_NXT;
                        end else begin
                            state_d = ST_WAIT_TICK;
                        end
                    end
                end
                ST_FETCH_NXT: begin
                    under_d = tick;
                    if (fetch_done) state_d = ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (tick) begin
                        dac_d = sample;
                        adv   = 1'b1;
                        case (mode_q)
                            MODE_FAST: new_ptr = {1'b0, ptr_q} + (ADDR_W+1)'(n_val);
                            MODE_SLOW: begin
                                if (k_last) begin
                                    k_d = '0;
                                end else begin
                                    k_d = k_q + 3'd1;
                                    adv = 1'b0;
                                end
                            end
                            default: new_ptr = ptr_inc1;
                        endcase
                        if (adv) begin
                            if (new_ptr > end_ext) begin
                                state_d = ST_DONE;
                            end else begin
                                ptr_d   = new_ptr[ADDR_W-1:0];
                                addr_d  = new_ptr[ADDR_W-1:0];
                                rd_d    = 1'b1;
                                pend_d  = PEND_CUR;
                                wait_d  = LAT_W'(RD_LAT);
                                state_d = ST_FETCH_CUR;
                            end
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        en_d   = state_d inside {ST_FETCH_CUR, ST_FETCH_NXT, ST_WAIT_TICK};
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_NORMAL;
            pend_q   <= PEND_NONE;
            rate_q   <= '0;
            interp_q <= 1'b0;
            ptr_q    <= '0;
            k_q      <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            wait_q   <= '0;
            lrck_q   <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            dac_q    <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            rate_q   <= rate_d;
            interp_q <= interp_d;
            ptr_q    <= ptr_d;
            k_q      <= k_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            wait_q   <= wait_d;
            lrck_q   <= i_daclrck;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            dac_q    <= dac_d;
            en_q     <= en_d;
            done_q   <= done_d;
            under_q  <= under_d;
        end
    end

    assign o_state     = state_q;
    assign o_sram_addr = addr_q;
    assign o_sram_rd   = rd_q;
    assign o_dac_data  = dac_q;
    assign o_player_en = en_q;
    assign o_done      = done_q;
    assign o_underrun  = under_q;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// Directed bench for aud_play_ctrl: a queue-based playback model predicts
// read addresses and emitted samples; a negedge process checks every cycle.
module tb_aud_play_ctrl;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, start, pause, stop, fast, slow, interp, lrck;
    logic [1:0]    rl2;
    logic [AW-1:0] end_addr, sram_addr;
    logic          sram_rd, en, done, under;
    logic [DW-1:0] sram_data, dac;
    logic [2:0]    st;

    always #5 clk = ~clk;

    aud_play_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_fast      (fast),
        .i_slow      (slow),
        .i_rate_log2 (rl2),
        .i_interp    (interp),
        .i_end_addr  (end_addr),
        .i_daclrck   (lrck),
        .o_sram_addr (sram_addr),
        .o_sram_rd   (sram_rd),
        .i_sram_data (sram_data),
        .o_dac_data  (dac),
        .o_player_en (en),
        .o_state     (st),
        .o_done      (done),
        .o_underrun  (under)
    );

    logic signed [DW-1:0] mem [0:63];
    always @(posedge clk) if (sram_rd) sram_data <= mem[sram_addr[5:0]];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_out[$];
    int   exp_rd[$];
    int   exp_dac;
    logic exp_en, exp_done, exp_under;
    bit   chk_on;
    int   rd_cnt = 0;
    int   rd_base;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int fdiv(input int a, input int n);
        if (a >= 0) return a / n;
        return -((-a + n - 1) / n);
    endfunction

    // What a whole playback must look like, straight from the speed rules.
    task automatic build_model(input int e, input bit f, input bit s, input int r, input bit ip);
        int n, c, x, q;
        n = 1 << r;
        exp_out.delete();
        exp_rd.delete();
        if (f) begin
            for (int p = 0; p <= e; p += n) begin
                exp_rd.push_back(p);
                exp_out.push_back(int'(mem[p]));
            end
        end else begin
            for (int p = 0; p <= e; p++) begin
                exp_rd.push_back(p);
                c = mem[p];
                x = c;
                if (s && ip) begin
                    q = (p + 1 > e) ? e : p + 1;
                    exp_rd.push_back(q);
                    x = mem[q];
                end
                if (s) for (int k = 0; k < n; k++) exp_out.push_back(ip ? c + fdiv((x - c) * k, n) : c);
                else exp_out.push_back(c);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (sram_rd === 1'b1) begin
                rd_cnt++;
                if (exp_rd.size() == 0) chk("unexpected_rd", {12'd0, sram_addr}, -1);
                else chk("rd_addr", {12'd0, sram_addr}, exp_rd.pop_front());
            end
            chk("dac_data", $signed(dac), exp_dac);
            chk("player_en", {31'd0, en}, {31'd0, exp_en});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("underrun", {31'd0, under}, {31'd0, exp_under});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_mode(input bit f, input bit s, input int r, input bit ip, input int e);
        fast = f; slow = s; rl2 = 2'(r); interp = ip; end_addr = AW'(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_en = 1'b1;
    endtask

    task automatic tick(input bit consume, input int gap);
        lrck = 1'b1;
        @(posedge clk); #1;
        lrck = 1'b0;
        if (consume) begin
            if (exp_out.size() == 0) chk("model_underflow", 1, 0);
            else begin
                exp_dac = exp_out.pop_front();
                if (exp_out.size() == 0) begin
                    exp_en   = 1'b0;
                    exp_done = 1'b1;
                    @(posedge clk); #1;
                    exp_done = 1'b0;
                end
            end
        end
        idle(gap);
    endtask

    task automatic play_all(input int pre, input int gap);
        do_start();
        idle(pre);
        while (exp_out.size() > 0) tick(1'b1, gap);
        idle(2);
        chk("reads_left", exp_rd.size(), 0);
        chk("end_state", {29'd0, st}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; pause = 0; stop = 0; lrck = 0;
        set_mode(0, 0, 0, 0, 0);
        exp_dac = 0; exp_en = 0; exp_done = 0; exp_under = 0; chk_on = 0;
        for (int i = 0; i < 64; i++) mem[i] = DW'(i * 100);
        @(posedge clk); #1;
        chk("rst_state", {29'd0, st}, 0);
        chk("rst_addr", {12'd0, sram_addr}, 0);
        chk("rst_rd", {31'd0, sram_rd}, 0);
        chk("rst_dac", $signed(dac), 0);
        chk("rst_en", {31'd0, en}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_underrun", {31'd0, under}, 0);
        idle(2);
        rst = 1'b0;
        chk_on = 1;
        idle(3);

        // Normal play; mode inputs wiggled after start must not matter.
        set_mode(0, 0, 0, 0, 3);
        build_model(3, 0, 0, 0, 0);
        chk("model_norm_len", exp_out.size(), 4);
        chk("model_norm_3", exp_out[3], 300);
        do_start();
        fast = 1'b1; rl2 = 2'd3;
        idle(5);
        while (exp_out.size() > 0) tick(1'b1, 5);
        fast = 1'b0; rl2 = 2'd0;
        chk("norm_reads_left", exp_rd.size(), 0);
        chk("norm_final_dac", $signed(dac), 300);

        // Single-sample record.
        set_mode(0, 0, 0, 0, 0);
        build_model(0, 0, 0, 0, 0);
        chk("model_end0_len", exp_out.size(), 1);
        play_all(5, 5);

        // Fast N=4.
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        set_mode(1, 0, 2, 0, 9);
        build_model(9, 1, 0, 2, 0);
        chk("model_fast_len", exp_out.size(), 3);
        chk("model_fast_2", exp_out[2], 8);
        rd_base = rd_cnt;
        play_all(5, 5);
        chk("fast_read_count", rd_cnt - rd_base, 3);

        // Slow interp N=4, rising then falling ramp.
        mem[0] = 16'sd0; mem[1] = 16'sd400;
        set_mode(0, 1, 2, 1, 1);
        build_model(1, 0, 1, 2, 1);
        chk("model_up_len", exp_out.size(), 8);
        chk("model_up_1", exp_out[1], 100);
        chk("model_up_3", exp_out[3], 300);
        chk("model_up_4", exp_out[4], 400);
        play_all(7, 6);
        mem[1] = -16'sd400;
        build_model(1, 0, 1, 2, 1);
        chk("model_dn_2", exp_out[2], -200);
        chk("model_dn_3", exp_out[3], -300);
        play_all(7, 6);

        // Slow hold N=2.
        mem[0] = 16'sd10; mem[1] = 16'sd20;
        set_mode(0, 1, 1, 0, 1);
        build_model(1, 0, 1, 1, 0);
        chk("model_hold_1", exp_out[1], 10);
        chk("model_hold_2", exp_out[2], 20);
        play_all(5, 5);

        // Pause after the second tick, ticks ignored, resume refetches ptr 2.
        for (int i = 0; i < 64; i++) mem[i] = DW'(i * 100);
        set_mode(0, 0, 0, 0, 3);
        build_model(3, 0, 0, 0, 0);
        do_start();
        idle(5);
        tick(1'b1, 5);
        tick(1'b1, 0);
        pause = 1'b1;
        @(posedge clk); #1;
        pause = 1'b0;
        exp_en = 1'b0;
        chk("pause_state", {29'd0, st}, 4);
        repeat (5) tick(1'b0, 3);
        chk("pause_dac_held", $signed(dac), 100);
        exp_rd.push_front(2);
        do_start();
        idle(5);
        while (exp_out.size() > 0) tick(1'b1, 5);
        chk("pause_reads_left", exp_rd.size(), 0);
        chk("pause_final_dac", $signed(dac), 300);

        // Stop while fetching: back to IDLE, data cleared, no done.
        build_model(3, 0, 0, 0, 0);
        do_start();
        idle(5);
        tick(1'b1, 5);
        tick(1'b1, 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        exp_dac = 0; exp_en = 1'b0;
        exp_rd.delete(); exp_out.delete();
        chk("stop_state", {29'd0, st}, 0);
        idle(3);
        tick(1'b0, 4);

        // Underrun: tick lands while the post-advance fetch is still pending.
        set_mode(0, 0, 0, 0, 2);
        build_model(2, 0, 0, 0, 0);
        do_start();
        idle(5);
        tick(1'b1, 5);
        tick(1'b1, 0);
        @(posedge clk); #1;
        lrck = 1'b1;
        @(posedge clk); #1;
        lrck = 1'b0;
        exp_under = 1'b1;
        @(posedge clk); #1;
        exp_under = 1'b0;
        chk("underrun_dac_held", $signed(dac), 100);
        idle(4);
        tick(1'b1, 5);
        chk("underrun_next_dac", $signed(dac), 200);
        chk("underrun_reads_left", exp_rd.size(), 0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
